// File: rtl/xgriscv_membus.sv
// Single-master to NSLV-slave memory bus bridge with address-region decode.
// Optional ACCESS timeout is enabled by defining XGRISCV_MEMBUS_TIMEOUT_EN.
module xgriscv_membus #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int NSLV = 4,
  parameter int RGN_LOG2 = 16,
  parameter logic [AW-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int TMO_CYC = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m_req,
  input  logic                  m_we,
  input  logic [AW-1:0]         m_addr,
  input  logic [DW-1:0]         m_wdata,
  input  logic [DW/8-1:0]       m_be,
  output logic [DW-1:0]         m_rdata,
  output logic                  m_ready,
  output logic                  m_err,
  output logic [NSLV-1:0]       s_sel,
  output logic                  s_we,
  output logic [RGN_LOG2-1:0]   s_addr,
  output logic [DW-1:0]         s_wdata,
  output logic [DW/8-1:0]       s_be,
  input  logic [NSLV*DW-1:0]    s_rdata,
  input  logic [NSLV-1:0]       s_ack
);

  localparam int IW = $clog2(NSLV);
  localparam int BW = DW / 8;

  // Widened by one bit so the end of the window never wraps.
  localparam logic [AW:0] LO = {1'b0, BASE_ADDR};
  localparam logic [AW:0] HI = LO + ((AW+1)'(NSLV) << RGN_LOG2);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } st_t;

  st_t st;
  st_t st_nx;

  logic                we_q;
  logic [RGN_LOG2-1:0] addr_q;
  logic [DW-1:0]       wdata_q;
  logic [BW-1:0]       be_q;
  logic [IW-1:0]       idx_q;
  logic                err_q;
  logic [DW-1:0]       rdata_q;

  logic          in_rng;
  logic          acc;
  logic          sel_ack;
  logic [DW-1:0] rd_sel;
  logic          tmo;

  assign in_rng = ({1'b0, m_addr} >= LO) && ({1'b0, m_addr} < HI);
  assign acc = (st == ACCESS);
  assign sel_ack = s_ack[idx_q];

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (idx_q == IW'(i)) rd_sel = s_rdata[i*DW +: DW];
    end
  end

`ifdef XGRISCV_MEMBUS_TIMEOUT_EN
  logic [7:0] tcnt;

  assign tmo = acc && !sel_ack && (tcnt + 8'd1 == 8'(TMO_CYC));

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt <= '0;
    end else if (st == IDLE) begin
      tcnt <= '0;
    end else if (acc && !sel_ack) begin
      tcnt <= tcnt + 8'd1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) st <= IDLE;
    else st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    case (st)
      IDLE: begin
        if (m_req) st_nx = in_rng ? ACCESS : RESP;
      end
      ACCESS: begin
        if (sel_ack || tmo) st_nx = RESP;
      end
      RESP: st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (st == IDLE && m_req) begin
        we_q    <= m_we;
        addr_q  <= m_addr[RGN_LOG2-1:0];
        wdata_q <= m_wdata;
        be_q    <= m_be;
        idx_q   <= m_addr[RGN_LOG2 +: IW];
        err_q   <= !in_rng;
      end
      // Ack beats a timeout landing in the same cycle.
      if (acc && sel_ack) begin
        rdata_q <= we_q ? '0 : rd_sel;
        err_q   <= 1'b0;
      end else if (tmo) begin
        err_q <= 1'b1;
      end
    end
  end

  assign m_ready = (st == RESP);
  assign m_err   = (st == RESP) && err_q;
  assign m_rdata = rdata_q;

  assign s_sel   = acc ? (NSLV'(1) << idx_q) : '0;
  assign s_we    = acc && we_q;
  assign s_addr  = acc ? addr_q : '0;
  assign s_wdata = acc ? wdata_q : '0;
  assign s_be    = acc ? be_q : '0;

endmodule

// File: tb/tb_xgriscv_membus.sv
// Scoreboard bench for xgriscv_membus with a behavioural slave responder.
// Timeout path checked when XGRISCV_MEMBUS_TIMEOUT_EN is defined.
module tb_xgriscv_membus;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NSLV = 4;
  localparam int RG = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              m_req;
  logic              m_we;
  logic [AW-1:0]     m_addr;
  logic [DW-1:0]     m_wdata;
  logic [DW/8-1:0]   m_be;
  logic [DW-1:0]     m_rdata;
  logic              m_ready;
  logic              m_err;
  logic [NSLV-1:0]   s_sel;
  logic              s_we;
  logic [RG-1:0]     s_addr;
  logic [DW-1:0]     s_wdata;
  logic [DW/8-1:0]   s_be;
  logic [NSLV*DW-1:0] s_rdata;
  logic [NSLV-1:0]   s_ack = '0;

  xgriscv_membus dut (
    .clk(clk),
    .reset(reset),
    .m_req(m_req),
    .m_we(m_we),
    .m_addr(m_addr),
    .m_wdata(m_wdata),
    .m_be(m_be),
    .m_rdata(m_rdata),
    .m_ready(m_ready),
    .m_err(m_err),
    .s_sel(s_sel),
    .s_we(s_we),
    .s_addr(s_addr),
    .s_wdata(s_wdata),
    .s_be(s_be),
    .s_rdata(s_rdata),
    .s_ack(s_ack)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] rd;
    logic          err;
  } exp_t;

  exp_t sb[$];

  logic [DW-1:0] slv_val [NSLV];
  int  ack_dly = 0;
  bit  no_ack = 0;
  bit  noise = 1;
  bit  force_ack = 0;
  int  acnt = 0;
  int  cyc = 0;
  logic [DW-1:0] lrd = '0;

  always_comb begin
    for (int i = 0; i < NSLV; i++) s_rdata[i*DW +: DW] = slv_val[i];
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: selected slave acks after ack_dly ACCESS cycles;
  // unselected slaves raise noise acks that must be ignored.
  always @(negedge clk) begin
    logic [NSLV-1:0] a;
    a = '0;
    if (s_sel != '0) begin
      if (!no_ack && acnt == ack_dly) a = s_sel;
      acnt++;
      if (noise) a = a | ~s_sel;
    end else begin
      acnt = 0;
    end
    if (force_ack) a = '1;
    s_ack = a;
  end

  logic prev_rdy = 1'b0;
  int   last_rdy = -100;
  int   gap = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!m_ready && m_err) chk("err_outside_resp", m_err, 1'b0);
    if (m_ready) begin
      chk("rdy_one_cycle", prev_rdy, 1'b0);
      if (sb.size() == 0) begin
        chk("rdy_unexpected", m_ready, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("m_rdata", m_rdata, e.rd);
        chk("m_err", m_err, e.err);
      end
      gap = cyc - last_rdy;
      last_rdy = cyc;
    end
    prev_rdy = m_ready;
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_s_sel"}, s_sel, 0);
    chk({tag, "_s_we"}, s_we, 0);
    chk({tag, "_s_addr"}, s_addr, 0);
    chk({tag, "_s_wdata"}, s_wdata, 0);
    chk({tag, "_s_be"}, s_be, 0);
    chk({tag, "_m_ready"}, m_ready, 0);
    chk({tag, "_m_err"}, m_err, 0);
    chk({tag, "_m_rdata"}, m_rdata, 0);
  endtask

  // Called at a negedge; payload is scrambled during ACCESS to show
  // the latched transaction is unaffected.
  task automatic xfer(input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic [3:0] be,
                      input logic [3:0] esel, input logic [DW-1:0] erd,
                      input logic eerr, input int elat, input int eacc,
                      input bit keep);
    exp_t e;
    int k;
    int nacc;
    bit done;
    e.rd = erd;
    e.err = eerr;
    sb.push_back(e);
    m_req = 1'b1;
    m_we = we;
    m_addr = a;
    m_wdata = wd;
    m_be = be;
    @(posedge clk);
    k = 0;
    nacc = 0;
    done = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
      if (m_ready) begin
        done = 1;
      end else if (s_sel != '0) begin
        nacc++;
        chk("s_sel", s_sel, esel);
        chk("s_we", s_we, we);
        chk("s_addr", s_addr, a[RG-1:0]);
        chk("s_wdata", s_wdata, wd);
        chk("s_be", s_be, be);
        m_we = ~we;
        m_addr = $urandom;
        m_wdata = $urandom;
        m_be = ~be;
      end
    end
    chk("latency", k, elat);
    chk("access_cycles", nacc, eacc);
    m_req = keep;
    if (!keep) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    m_req = 1'b0;
    m_we = 1'b0;
    m_addr = '0;
    m_wdata = '0;
    m_be = '0;
    slv_val[0] = 32'h1111_0000;
    slv_val[1] = 32'hDEAD_BEEF;
    slv_val[2] = 32'h2222_0002;
    slv_val[3] = 32'hCAFE_F00D;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;

    ack_dly = 0;
    xfer(1'b0, 32'h0001_0004, '0, 4'hF, 4'b0010,
         32'hDEAD_BEEF, 1'b0, 2, 1, 0);
    lrd = 32'hDEAD_BEEF;

    xfer(1'b0, 32'h0004_0000, '0, 4'hF, 4'b0000,
         lrd, 1'b1, 1, 0, 0);

    ack_dly = 2;
    xfer(1'b1, 32'h0003_FFFC, 32'h1234_5678, 4'b0011, 4'b1000,
         32'h0, 1'b0, 4, 3, 0);
    lrd = '0;

    ack_dly = 0;
    slv_val[2] = 32'hA5A5_0002;
    slv_val[0] = 32'h5A5A_0000;
    xfer(1'b0, 32'h0002_0010, '0, 4'hF, 4'b0100,
         32'hA5A5_0002, 1'b0, 2, 1, 1);
    xfer(1'b0, 32'h0000_0020, '0, 4'hF, 4'b0001,
         32'h5A5A_0000, 1'b0, 3, 1, 0);
    chk("b2b_gap", gap, 3);
    lrd = 32'h5A5A_0000;

`ifdef XGRISCV_MEMBUS_TIMEOUT_EN
    no_ack = 1;
    xfer(1'b0, 32'h0001_0100, '0, 4'hF, 4'b0010,
         lrd, 1'b1, 16, 15, 0);
    no_ack = 0;
`else
    begin
      int rdy;
      rdy = 0;
      no_ack = 1;
      m_req = 1'b1;
      m_we = 1'b0;
      m_addr = 32'h0001_0100;
      m_wdata = '0;
      m_be = 4'hF;
      repeat (100) begin
        @(negedge clk);
        if (m_ready) rdy++;
      end
      chk("no_timeout_ready", rdy, 0);
      chk("still_access_sel", s_sel, 4'b0010);
      reset = 1'b1;
      m_req = 1'b0;
      @(negedge clk);
      chk_zero("abort_wait");
      reset = 1'b0;
      no_ack = 0;
      lrd = '0;
    end
`endif

    no_ack = 1;
    m_req = 1'b1;
    m_we = 1'b0;
    m_addr = 32'h0001_0008;
    m_wdata = '0;
    m_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    chk("rst_acc1_sel", s_sel, 4'b0010);
    @(negedge clk);
    chk("rst_acc2_sel", s_sel, 4'b0010);
    reset = 1'b1;
    m_req = 1'b0;
    @(negedge clk);
    chk_zero("mid_reset");
    reset = 1'b0;
    no_ack = 0;
    lrd = '0;
    force_ack = 1;
    repeat (2) begin
      @(negedge clk);
      chk("late_ack_ready", m_ready, 0);
    end
    force_ack = 0;

    xfer(1'b0, 32'h0001_0004, '0, 4'hF, 4'b0010,
         32'hDEAD_BEEF, 1'b0, 2, 1, 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/xgriscv_membus.md
XGRISCV_MEMBUS -- requirements
Module: xgriscv_membus

Interface
REQ-001 SHALL have parameter DW, default 32, data width in bits (multiple of 8).
REQ-002 SHALL have parameter AW, default 32, address width in bits.
REQ-003 SHALL have parameter NSLV, default 4, slave count (power of two, 2..16).
REQ-004 SHALL have parameter RGN_LOG2, default 16, log2 of bytes per slave region.
REQ-005 SHALL have parameter BASE_ADDR, default 32'h0000_0000, region-0 start (aligned to NSLV<<RGN_LOG2).
REQ-006 SHALL have parameter TMO_CYC, default 15, timeout limit in cycles (1..255).
REQ-007 SHALL have ports clk in 1 (sole clock, rising edge) and reset in 1 (synchronous, active-high).
REQ-008 SHALL have ports m_req in 1 (master request), m_we in 1 (write), m_addr in AW, m_wdata in DW, m_be in DW/8 (byte enables).
REQ-009 SHALL have ports m_rdata out DW, m_ready out 1 (one-cycle completion pulse), m_err out 1 (error, valid with m_ready).
REQ-010 SHALL have ports s_sel out NSLV (one-hot select), s_we out 1, s_addr out RGN_LOG2 (region offset), s_wdata out DW, s_be out DW/8.
REQ-011 SHALL have ports s_rdata in NSLV*DW (slave i at bits [i*DW +: DW]) and s_ack in NSLV.

Function
REQ-012 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-013 IDLE with m_req=1 SHALL latch we/addr/wdata/be and decoded index, then go to ACCESS when m_addr lies in [BASE_ADDR, BASE_ADDR+(NSLV<<RGN_LOG2)), else go to RESP with error flag set.
REQ-014 Slave index SHALL be m_addr[RGN_LOG2 +: log2(NSLV)]; s_addr SHALL be latched m_addr[RGN_LOG2-1:0].
REQ-015 In ACCESS, s_sel SHALL be one-hot on the latched index; s_we/s_addr/s_wdata/s_be SHALL hold latched values; all s_* outputs SHALL be 0 outside ACCESS.
REQ-016 In ACCESS, s_ack of the selected slave SHALL capture its s_rdata (reads; 0 for writes) and move to RESP; s_ack of unselected slaves SHALL be ignored.
REQ-017 RESP SHALL assert m_ready for exactly one cycle with m_rdata and m_err valid, then return to IDLE.
REQ-018 m_rdata SHALL hold its last value outside RESP; m_err SHALL be 0 outside RESP.
REQ-019 Minimum latency: request sampled in cycle N, s_sel in N+1, ack in N+1 gives m_ready in N+2; ack at N+k gives m_ready at N+k+1.
REQ-020 Out-of-range request SHALL give m_ready=1, m_err=1, m_rdata unchanged in cycle N+1 with no slave selected.
REQ-021 Master SHALL hold m_req and payload stable until m_ready; m_req in RESP SHALL be ignored, and a request held after m_ready SHALL be accepted as new in the following IDLE cycle.
REQ-022 Changes on m_* during ACCESS SHALL NOT affect the transaction in progress.

Reset
REQ-023 reset=1 at a rising edge SHALL force IDLE, clear timeout counter, and set s_sel=0, s_we=0, s_addr=0, s_wdata=0, s_be=0, m_ready=0, m_err=0, m_rdata=0.
REQ-024 Reset during ACCESS or RESP SHALL abort the transaction with no m_ready pulse; reset has priority over every other event.

Configuration
REQ-025 With XGRISCV_MEMBUS_TIMEOUT_EN defined, an 8-bit counter SHALL clear on ACCESS entry, increment each ACCESS cycle without ack, and on reaching TMO_CYC force RESP with m_err=1 and m_rdata unchanged; an ack in that same cycle SHALL win (normal completion).
REQ-026 Without XGRISCV_MEMBUS_TIMEOUT_EN, no counter SHALL exist and ACCESS SHALL wait indefinitely for s_ack; TMO_CYC SHALL be unused.

Verification
REQ-027 Reset then read 0x0001_0004, slave 1 acks in first ACCESS cycle with 0xDEADBEEF -> s_sel=4'b0010, s_addr=0x0004, m_ready one cycle at N+2, m_rdata=0xDEADBEEF, m_err=0.
REQ-028 Write 0x0003_FFFC, data 0x12345678, be=4'b0011, slave 3 acks after 3 cycles -> s_sel=4'b1000, s_we=1, s_be=4'b0011 held 3 cycles, m_ready at N+4, m_err=0.
REQ-029 Read 0x0004_0000 (out of range, defaults) -> m_ready=1, m_err=1 at N+1, s_sel=0 throughout, m_rdata unchanged.
REQ-030 TIMEOUT_EN defined, TMO_CYC=15, slave never acks -> m_ready=1, m_err=1 after 15 ACCESS cycles; undefined -> no m_ready after 100 cycles.
REQ-031 reset asserted in second ACCESS cycle of a read -> all outputs 0 next cycle, no m_ready pulse, late ack ignored, next request completes normally.
REQ-032 Back-to-back reads with m_req held high, slave 2 then slave 0, each acking immediately -> two m_ready pulses 3 cycles apart with correct data each.
